// File: rtl/key_expansion_pkg.sv
// Shared constants, state encoding and round-constant table for the AES-128 key schedule.
package key_expansion_pkg;

   localparam int unsigned BYTE    = 8;
   localparam int unsigned DWORD   = 32;
   localparam int unsigned LENGTH  = 128;
   localparam int unsigned NROUNDS = 10;

   localparam logic [3:0] LAST_ROUND = 4'(NROUNDS);

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StEmit = 2'd1,
      StDone = 2'd2
   } state_e;

   // Index is the round being produced (1..10); anything else yields zero.
   function automatic logic [BYTE-1:0] rcon(input logic [3:0] idx);
      logic [BYTE-1:0] r;
      case (idx)
         4'd1:    r = 8'h01;
         4'd2:    r = 8'h02;
         4'd3:    r = 8'h04;
         4'd4:    r = 8'h08;
         4'd5:    r = 8'h10;
         4'd6:    r = 8'h20;
         4'd7:    r = 8'h40;
         4'd8:    r = 8'h80;
         4'd9:    r = 8'h1b;
         4'd10:   r = 8'h36;
         default: r = 8'h00;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/key_expansion_subword.sv
// AES SubWord: four parallel S-box lookups, each computed as GF(2^8) inverse plus affine map.
module key_expansion_subword
   import key_expansion_pkg::*;
(
   input  logic [DWORD-1:0] din,
   output logic [DWORD-1:0] dout
);

   function automatic logic [BYTE-1:0] gf_mul(input logic [BYTE-1:0] a, input logic [BYTE-1:0] b);
      logic [BYTE-1:0] p;
      logic [BYTE-1:0] x;
      p = '0;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // x^254 == x^-1 in GF(2^8), and maps 0 to 0 as the S-box requires.
   function automatic logic [BYTE-1:0] gf_inv(input logic [BYTE-1:0] x);
      logic [BYTE-1:0] sq;
      logic [BYTE-1:0] acc;
      sq  = gf_mul(x, x);
      acc = sq;
      for (int i = 0; i < 6; i++) begin
         sq  = gf_mul(sq, sq);
         acc = gf_mul(acc, sq);
      end
      return acc;
   endfunction

   function automatic logic [BYTE-1:0] sbox(input logic [BYTE-1:0] x);
      logic [BYTE-1:0] b;
      b = gf_inv(x);
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

   for (genvar i = 0; i < 4; i++) begin : g_sbox
      assign dout[i*BYTE +: BYTE] = sbox(din[i*BYTE +: BYTE]);
   end

endmodule

// File: rtl/key_expansion.sv
// AES-128 key schedule: emits round keys 0..10 one per handshake, computing each next key in
// a single combinational step from the currently presented one.
module key_expansion
   import key_expansion_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [LENGTH-1:0] key_in,
   output logic              busy,
   output logic              rk_valid,
   input  logic              rk_ready,
   output logic [3:0]        rk_round,
   output logic [LENGTH-1:0] rk_out,
   output logic              done
);

   state_e            state_q, state_d;
   logic [LENGTH-1:0] rk_q, rk_d;
   logic [3:0]        round_q, round_d;
   logic              done_q, done_d;

   logic [DWORD-1:0]  w0, w1, w2, w3;
   logic [DWORD-1:0]  rot, sub, t;
   logic [DWORD-1:0]  n0, n1, n2, n3;
   logic [3:0]        next_round;
   logic [LENGTH-1:0] rk_next;

   assign {w0, w1, w2, w3} = rk_q;
   assign rot        = {w3[23:0], w3[31:24]};
   assign next_round = round_q + 4'd1;

   key_expansion_subword u_subword (
      .din  (rot),
      .dout (sub)
   );

   assign t       = sub ^ {rcon(next_round), 24'h0};
   assign n0      = w0 ^ t;
   assign n1      = w1 ^ n0;
   assign n2      = w2 ^ n1;
   assign n3      = w3 ^ n2;
   assign rk_next = {n0, n1, n2, n3};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         rk_q    <= '0;
         round_q <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         rk_q    <= rk_d;
         round_q <= round_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      rk_d    = rk_q;
      round_d = round_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StEmit;
               rk_d    = key_in;
               round_d = '0;
            end
         end
         StEmit: begin
            // Hold key and index until the consumer takes them.
            if (rk_ready) begin
               if (round_q == LAST_ROUND) begin
                  state_d = StDone;
               end else begin
                  rk_d    = rk_next;
                  round_d = next_round;
               end
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
      done_d = (state_d == StDone);
   end

   always_comb begin
      busy     = (state_q != StIdle);
      rk_valid = (state_q == StEmit);
      rk_round = round_q;
      rk_out   = rk_q;
      done     = done_q;
   end

endmodule
